// File: rtl/lockpick_pkg.sv
// Shared types and constants for the lockpick hash arbiter.
// No logic; FSM states, response status codes and the challenge target.
// Imported by the arbiter top and its round-robin picker.
package lockpick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STAT_TIMEOUT = 2'b00,
        STAT_ERROR   = 2'b01,
        STAT_WIN     = 2'b10,
        STAT_LOCKED  = 2'b11
    } status_t;

    localparam logic [127:0] CHALLENGE_TARGET = 128'hCAFEBABE_12345678_DEADBEEF_FEEDFACE;

endpackage

// File: rtl/lockpick_rr_pick.sv
// Round-robin picker: first set bit of mask at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
module lockpick_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             vld
);

    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        vld  = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!vld && mask[idx]) begin
                pick[idx] = 1'b1;
                vld       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lockpick_hash_arbiter.sv
// Arbitrates N_REQ requesters onto one external hash engine, tracking failed attempts per requester.
// Latency: req in IDLE at t -> eng_start at t+1; eng_done at t+k -> resp_valid at t+k+1.
// Backpressure: one transaction in flight; req is a level held until resp_valid, locked requesters skipped.
module lockpick_hash_arbiter
    import lockpick_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_ATTEMPTS = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*128-1:0] key_in,
    input  logic [N_REQ-1:0]     unlock,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [127:0]         resp_hash,
    output logic [1:0]           resp_status,
    output logic [N_REQ-1:0]     locked,
    output logic                 eng_start,
    output logic [127:0]         eng_key,
    input  logic                 eng_done,
    input  logic [127:0]         eng_hash
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     grant_q;
    logic [PTR_W-1:0]     gidx_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [TMR_W-1:0]     tmr_q;
    status_t              status_q;
    logic [CNT_W-1:0]     cnt_q [N_REQ];
    logic [CNT_W-1:0]     cnt_d [N_REQ];

    logic [N_REQ-1:0]     pick_oh;
    logic                 pick_vld;
    logic [PTR_W-1:0]     pick_idx;
    logic                 hit;
    logic                 tmo;
    logic [CNT_W-1:0]     g_cnt;
    logic [CNT_W-1:0]     mis_cnt;

    lockpick_rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .mask (req & ~locked),
        .ptr  (ptr_q),
        .pick (pick_oh),
        .vld  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick_oh[i]) pick_idx = PTR_W'(i);
    end

    assign hit     = (eng_hash == CHALLENGE_TARGET);
    assign tmo     = (tmr_q == TMR_W'(TIMEOUT - 1));
    assign g_cnt   = cnt_q[gidx_q];
    assign mis_cnt = (g_cnt == CNT_W'(MAX_ATTEMPTS)) ? g_cnt : g_cnt + 1'b1;
    assign resp_status = status_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        gnt        = '0;
        resp_valid = '0;
        eng_start  = 1'b0;
        case (state_q)
            ST_IDLE:    if (pick_vld) state_d = ST_ISSUE;
            ST_ISSUE: begin
                gnt       = grant_q;
                eng_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                gnt = grant_q;
                if (eng_done || tmo) state_d = ST_RESPOND;
            end
            ST_RESPOND: begin
                resp_valid = grant_q;
                state_d    = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Unlock is applied after the mismatch/win update so it always wins a same-cycle collision.
    always_comb begin
        locked = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (state_q == ST_WAIT && eng_done && gidx_q == PTR_W'(i))
                cnt_d[i] = hit ? '0 : mis_cnt;
            if (unlock[i]) cnt_d[i] = '0;
            locked[i] = (cnt_q[i] == CNT_W'(MAX_ATTEMPTS));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            tmr_q     <= '0;
            eng_key   <= '0;
            resp_hash <= '0;
            status_q  <= STAT_TIMEOUT;
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
            case (state_q)
                ST_IDLE: if (pick_vld) begin
                    grant_q <= pick_oh;
                    gidx_q  <= pick_idx;
                    eng_key <= key_in[32'(pick_idx)*128 +: 128];
                    ptr_q   <= (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
                end
                ST_ISSUE: tmr_q <= '0;
                ST_WAIT: begin
                    if (eng_done) begin
                        resp_hash <= eng_hash;
                        if (hit)
                            status_q <= STAT_WIN;
                        else if (mis_cnt == CNT_W'(MAX_ATTEMPTS))
                            status_q <= STAT_LOCKED;
                        else
                            status_q <= STAT_ERROR;
                    end else if (tmo) begin
                        resp_hash <= '0;
                        status_q  <= STAT_TIMEOUT;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lockpick_hash_arbiter.sv
// Bench for lockpick_hash_arbiter: drives requesters and a behavioural engine,
// predicts each response into a queue that a negedge monitor drains and compares.
module tb_lockpick_hash_arbiter;

    localparam logic [127:0] TARGET = 128'hCAFEBABE_12345678_DEADBEEF_FEEDFACE;
    localparam logic [127:0] BAD    = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [511:0]   key_in;
    logic [3:0]     unlock;
    logic [3:0]     gnt;
    logic [3:0]     resp_valid;
    logic [127:0]   resp_hash;
    logic [1:0]     resp_status;
    logic [3:0]     locked;
    logic           eng_start;
    logic [127:0]   eng_key;
    logic           eng_done;
    logic [127:0]   eng_hash;

    typedef struct {
        logic [3:0]   who;
        logic [1:0]   st;
        logic [127:0] h;
        int           cyc;
        bit           chk_st;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt[4];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;

    lockpick_hash_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .key_in      (key_in),
        .unlock      (unlock),
        .gnt         (gnt),
        .resp_valid  (resp_valid),
        .resp_hash   (resp_hash),
        .resp_status (resp_status),
        .locked      (locked),
        .eng_start   (eng_start),
        .eng_key     (eng_key),
        .eng_done    (eng_done),
        .eng_hash    (eng_hash)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] key_of(input int g);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(g);
        return {w, ~w, w ^ 32'h1357_9BDF, w + 32'h0101_0101};
    endfunction

    // Response monitor: every resp_valid must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst && resp_valid != 4'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", resp_valid, 4'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_valid", resp_valid, e.who);
                check("resp_hash", resp_hash, e.h);
                if (e.chk_st) check("resp_status", resp_status, e.st);
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // Act as the engine for one service of requester g.
    task automatic serve(input int g, input int dly, input logic [127:0] h, input bit do_done,
                         input logic [3:0] clr, input bit unl, input bit drop_early);
        exp_t e;
        int   b;
        logic [3:0] oh;
        oh = 4'b1 << g;
        b = 0;
        do begin @(negedge clk); b++; end while (!eng_start && b < 40);
        check("eng_start", eng_start, 1'b1);
        check("gnt_issue", gnt, oh);
        check("eng_key", eng_key, key_of(g));
        if (drop_early) req = req & ~oh;
        e.who = oh;
        e.chk_st = 1'b1;
        if (!do_done) begin
            e.st  = 2'b00;
            e.h   = '0;
            e.cyc = cyc + 16;
            exp_q.push_back(e);
        end else begin
            repeat (dly) @(negedge clk);
            check("gnt_hold", gnt, oh);
            eng_done = 1'b1;
            eng_hash = h;
            if (unl) unlock = oh;
            if (h == TARGET) begin
                m_cnt[g] = 0;
                e.st = 2'b10;
            end else begin
                m_cnt[g] = (m_cnt[g] < 3) ? m_cnt[g] + 1 : 3;
                e.st = (m_cnt[g] == 3) ? 2'b11 : 2'b01;
            end
            if (unl) begin
                m_cnt[g] = 0;
                e.chk_st = 1'b0;
            end
            e.h   = h;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
            eng_done = 1'b0;
            eng_hash = $urandom();
            unlock   = '0;
            req      = req & ~clr;
        end
        b = 0;
        while (exp_q.size() != 0 && b < 40) begin @(negedge clk); b++; end
        check("resp_seen", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit saw;
        rst      = 1'b1;
        req      = '0;
        unlock   = '0;
        eng_done = 1'b0;
        eng_hash = '0;
        for (int g = 0; g < 4; g++) begin
            key_in[g*128 +: 128] = key_of(g);
            m_cnt[g] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 4'b0);
        check("rst_resp_valid", resp_valid, 4'b0);
        check("rst_resp_hash", resp_hash, '0);
        check("rst_resp_status", resp_status, 2'b00);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_eng_key", eng_key, '0);
        check("rst_locked", locked, 4'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single requester, win, done three cycles after start.
        req = 4'b0001;
        serve(0, 3, TARGET, 1'b1, 4'b0001, 1'b0, 1'b0);
        check("single_locked", locked, 4'b0);

        // Reset in WAIT, then a stray eng_done.
        req = 4'b0100;
        saw = 1'b0;
        for (int i = 0; i < 40 && !saw; i++) begin @(negedge clk); saw = eng_start; end
        check("rw_start", saw, 1'b1);
        check("rw_gnt", gnt, 4'b0100);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        check("rw_async_gnt", gnt, 4'b0);
        @(negedge clk);
        check("rw_resp_hash", resp_hash, '0);
        check("rw_eng_key", eng_key, '0);
        check("rw_status", resp_status, 2'b00);
        rst = 1'b0;
        for (int g = 0; g < 4; g++) m_cnt[g] = 0;
        @(negedge clk);
        eng_done = 1'b1;
        eng_hash = TARGET;
        @(negedge clk);
        eng_done = 1'b0;
        saw = 1'b0;
        repeat (4) begin @(negedge clk); saw = saw | (resp_valid != 0) | eng_start; end
        check("rw_no_resp", saw, 1'b0);

        // Contention: grant order 0,1,2,3,0 starting from the reset pointer.
        req = 4'b1111;
        serve(0, 2, TARGET, 1'b1, 4'b0000, 1'b0, 1'b0);
        serve(1, 3, TARGET, 1'b1, 4'b0000, 1'b0, 1'b0);
        serve(2, 4, TARGET, 1'b1, 4'b0000, 1'b0, 1'b0);
        serve(3, 1, TARGET, 1'b1, 4'b0000, 1'b0, 1'b0);
        serve(0, 5, TARGET, 1'b1, 4'b1111, 1'b0, 1'b0);

        // req drops during ISSUE; response still delivered.
        req = 4'b1000;
        serve(3, 2, BAD, 1'b1, 4'b0000, 1'b0, 1'b1);
        check("drop_req", req, 4'b0);

        // Lockout of requester 2, ignored while locked, restored by unlock.
        req = 4'b0100;
        serve(2, 2, BAD, 1'b1, 4'b0000, 1'b0, 1'b0);
        serve(2, 3, BAD, 1'b1, 4'b0000, 1'b0, 1'b0);
        serve(2, 2, BAD, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("lock_locked", locked, 4'b0100);
        saw = 1'b0;
        repeat (10) begin @(negedge clk); saw = saw | eng_start; end
        check("lock_ignored", saw, 1'b0);
        unlock = 4'b0100;
        m_cnt[2] = 0;
        @(negedge clk);
        unlock = '0;
        check("lock_cleared", locked, 4'b0);
        serve(2, 2, TARGET, 1'b1, 4'b0100, 1'b0, 1'b0);

        // Timeout leaves the attempt counter alone.
        req = 4'b0001;
        serve(0, 2, BAD, 1'b1, 4'b0000, 1'b0, 1'b0);
        serve(0, 0, BAD, 1'b0, 4'b0000, 1'b0, 1'b0);
        serve(0, 2, BAD, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("tmo_not_locked", locked, 4'b0);
        serve(0, 3, BAD, 1'b1, 4'b0001, 1'b0, 1'b0);
        check("tmo_locked", locked, 4'b0001);
        unlock = 4'b0001;
        m_cnt[0] = 0;
        @(negedge clk);
        unlock = '0;

        // Unlock collides with the third mismatch of requester 1.
        req = 4'b0010;
        serve(1, 2, BAD, 1'b1, 4'b0000, 1'b0, 1'b0);
        serve(1, 2, BAD, 1'b1, 4'b0000, 1'b0, 1'b0);
        serve(1, 2, BAD, 1'b1, 4'b0000, 1'b1, 1'b0);
        check("collide_locked", locked, 4'b0);
        serve(1, 2, BAD, 1'b1, 4'b0010, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("end_queue", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/lockpick_hash_arbiter.md
LOCKPICK_HASH_ARBITER -- requirements
Module: lockpick_hash_arbiter

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter N_REQ, default 4: number of requesters (player ports).
REQ-003 SHALL have parameter MAX_ATTEMPTS, default 3: failed attempts before a requester is locked out.
REQ-004 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before the engine is abandoned.
REQ-005 SHALL have port clk  input  1: rising-edge clock.
REQ-006 SHALL have port rst  input  1: asynchronous active-high reset.
REQ-007 SHALL have port req  input  N_REQ: per-requester hash request, held until that requester's resp_valid.
REQ-008 SHALL have port key_in  input  N_REQ*128: per-requester key, slice i = key_in[i*128 +: 128].
REQ-009 SHALL have port unlock  input  N_REQ: per-requester pulse that clears its attempt counter.
REQ-010 SHALL have port gnt  output  N_REQ: one-hot grant to the requester currently in service.
REQ-011 SHALL have port resp_valid  output  N_REQ: one-cycle response pulse to the served requester.
REQ-012 SHALL have port resp_hash  output  128: hash returned by the engine; all-zero on timeout.
REQ-013 SHALL have port resp_status  output  2: 00 timeout, 01 error, 10 win, 11 locked out.
REQ-014 SHALL have port locked  output  N_REQ: requester i has attempts == MAX_ATTEMPTS.
REQ-015 SHALL have port eng_start  output  1: one-cycle start pulse to the shared Feistel hash engine.
REQ-016 SHALL have port eng_key  output  128: key of the granted requester, stable from ISSUE until the engine returns.
REQ-017 SHALL have port eng_done  input  1: engine completion pulse.
REQ-018 SHALL have port eng_hash  input  128: engine result, valid with eng_done.

Function
REQ-019 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESPOND.
REQ-020 IDLE: when any eligible requester is present (req[i] & ~locked[i]), SHALL pick one round-robin, starting after the last grantee (index 0 first after reset), capture its key_in slice, then go to ISSUE.
REQ-021 ISSUE: SHALL assert gnt one-hot and eng_start=1 for exactly one cycle, then go to WAIT.
REQ-022 WAIT: SHALL hold gnt; on eng_done, SHALL capture eng_hash, compare it with CHALLENGE_TARGET and go to RESPOND.
REQ-023 WAIT: if the cycle counter reaches TIMEOUT with no eng_done, SHALL go to RESPOND with status 00 and resp_hash = 0.
REQ-024 RESPOND: SHALL pulse resp_valid[g] for one cycle, present resp_hash and resp_status, drop gnt, and return to IDLE.
REQ-025 Latency: req seen in IDLE at cycle t gives ISSUE at t+1 and WAIT from t+2; eng_done at cycle t+k (k>=2) gives resp_valid at t+k+1.
REQ-026 On a match, SHALL report status 10 and clear the served requester's attempt counter.
REQ-027 On a mismatch, SHALL increment the attempt counter; status is 11 if the new count equals MAX_ATTEMPTS, else 01.
REQ-028 Attempt counters SHALL saturate at MAX_ATTEMPTS.
REQ-029 A timeout SHALL NOT change the attempt counter.
REQ-030 A locked requester SHALL be excluded from arbitration until it receives an unlock pulse.
REQ-031 If unlock[i] and a counter update for i occur in the same cycle, unlock SHALL win (counter = 0).
REQ-032 If req drops during ISSUE or WAIT, service SHALL still complete and resp_valid SHALL still be issued.
REQ-033 eng_done outside WAIT SHALL be ignored.
REQ-034 Only one request SHALL be in flight at a time; there is no queuing beyond the req levels.
REQ-035 Simultaneous requests SHALL be serviced strictly round-robin, so no eligible requester waits more than N_REQ-1 services.

Reset
REQ-036 rst SHALL asynchronously force: state IDLE, gnt=0, resp_valid=0, resp_hash=0, resp_status=00, eng_start=0, eng_key=0, all attempt counters=0, locked=0, round-robin pointer to index 0, timeout counter=0.
REQ-037 Reset asserted mid-service SHALL abandon the transaction with no resp_valid; a late eng_done after reset SHALL be ignored.

Structure
REQ-038 lockpick_pkg SHALL hold the FSM state enum, the resp_status codes and CHALLENGE_TARGET = 128'hCAFEBABE_12345678_DEADBEEF_FEEDFACE.
REQ-039 SHALL contain one sub-module, lockpick_rr_pick: a combinational round-robin picker taking request mask and pointer, returning a one-hot pick and a valid flag.
REQ-040 The hash engine SHALL be external; this block contains no Feistel datapath.

Verification
REQ-041 Single requester: req=0001, eng_done 3 cycles after eng_start with eng_hash=CHALLENGE_TARGET -> resp_valid=0001, status 10, counter 0.
REQ-042 Contention: req=1111 held continuously -> grant order 0,1,2,3,0 and each requester receives exactly one resp_valid per rotation.
REQ-043 Lockout: requester 2 receives three mismatches -> statuses 01, 01, 11; locked[2]=1 and req[2] is then ignored; an unlock[2] pulse restores service.
REQ-044 Timeout: engine never asserts eng_done -> resp_valid 16 cycles after ISSUE with status 00, resp_hash 0, counter unchanged.
REQ-045 Reset during WAIT, followed by a stray eng_done -> no resp_valid; outputs at reset values; next grant goes to requester 0.
REQ-046 unlock[1] in the same cycle as requester 1's third mismatch -> counter 0 and locked[1]=0.
